// File: rtl/barrier_gate_ctrl.sv
// ----------------------------------------------------------------------------
// barrier_gate_ctrl
//
// Barrier (talanquera) controller sitting behind the parking payment FSM.
// A rising edge on the open request starts the motor. The gate waits at the
// open limit for a vehicle, confirms it has passed and closes again. Limit
// switches and motor travel time are supervised; any fault is sticky until
// reset.
//
// Optional feature: define CONTADOR_EN to build the vehicle counter
// (contar/conteo). Without it both outputs are tied to zero and the FSM is
// unchanged.
//
// Ports:
//   clk            in   rising-edge system clock
//   reset          in   synchronous, active-low reset
//   talanquera     in   open request; only its rising edge in CERRADA counts
//   sensor         in   lane beam, 0 = vehicle under barrier, 1 = clear
//   lim_abierto    in   open limit switch, 1 = fully open
//   lim_cerrado    in   closed limit switch, 1 = fully closed
//   motor_abrir    out  drive motor in open direction
//   motor_cerrar   out  drive motor in close direction
//   puerta_abierta out  gate is open (ABIERTA or PASO)
//   falla          out  sticky fault flag
//   contar         out  one-cycle pulse per completed vehicle passage
//   conteo         out  vehicles passed since reset, wraps modulo 2^COUNT_W
// ----------------------------------------------------------------------------
module barrier_gate_ctrl #(
    parameter int unsigned TRAVEL_MAX = 64,
    parameter int unsigned PASS_MAX   = 200,
    parameter int unsigned CLEAR_HOLD = 4,
    parameter int unsigned COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               talanquera,
    input  logic               sensor,
    input  logic               lim_abierto,
    input  logic               lim_cerrado,
    output logic               motor_abrir,
    output logic               motor_cerrar,
    output logic               puerta_abierta,
    output logic               falla,
    output logic               contar,
    output logic [COUNT_W-1:0] conteo
);

    localparam int unsigned TimerMax = (TRAVEL_MAX > PASS_MAX) ? TRAVEL_MAX : PASS_MAX;
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;
    localparam int unsigned ClrW     = $clog2(CLEAR_HOLD + 1);

    localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_MAX - 1);
    localparam logic [TimerW-1:0] PassLast   = TimerW'(PASS_MAX - 1);
    localparam logic [ClrW-1:0]   ClrLast    = ClrW'(CLEAR_HOLD - 1);

    typedef enum logic [2:0] {
        StCerrada,
        StAbriendo,
        StAbierta,
        StPaso,
        StCerrando,
        StFalla
    } state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [ClrW-1:0]     clr_q, clr_d;
    logic                req_prev_q;
    logic                req_edge;
    logic                pass_done;

    assign req_edge = talanquera & ~req_prev_q;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pass_done = 1'b0;
        // Both limits at once means a broken switch; stop everything.
        if (state_q != StFalla && lim_abierto && lim_cerrado) begin
            state_d = StFalla;
        end else begin
            unique case (state_q)
                StCerrada: begin
                    if (req_edge) state_d = StAbriendo;
                end
                StAbriendo: begin
                    if (lim_abierto)                state_d = StAbierta;
                    else if (timer_q == TravelLast) state_d = StFalla;
                end
                StAbierta: begin
                    if (!sensor)                  state_d = StPaso;
                    else if (timer_q == PassLast) state_d = StCerrando;
                end
                StPaso: begin
                    if (sensor && clr_q == ClrLast) begin
                        state_d   = StCerrando;
                        pass_done = 1'b1;
                    end
                end
                StCerrando: begin
                    // Vehicle under a closing barrier reverses straight to opening.
                    if (!sensor)                    state_d = StAbriendo;
                    else if (lim_cerrado)           state_d = StCerrada;
                    else if (timer_q == TravelLast) state_d = StFalla;
                end
                StFalla: begin
                    state_d = StFalla;
                end
                default: begin
                    state_d = StFalla;
                end
            endcase
        end
    end

    // Shared timer: counts cycles spent in a timed state, clears on any change.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == StAbriendo || state_q == StAbierta || state_q == StCerrando)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Consecutive clear-beam cycles while in PASO.
    always_comb begin
        clr_d = '0;
        if (state_q == StPaso && state_d == StPaso && sensor) begin
            clr_d = clr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StCerrada;
            timer_q    <= '0;
            clr_q      <= '0;
            req_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            clr_q      <= clr_d;
            req_prev_q <= talanquera;
        end
    end

    // Moore outputs
    always_comb begin
        motor_abrir    = 1'b0;
        motor_cerrar   = 1'b0;
        puerta_abierta = 1'b0;
        falla          = 1'b0;
        unique case (state_q)
            StAbriendo: motor_abrir    = 1'b1;
            StCerrando: motor_cerrar   = 1'b1;
            StAbierta:  puerta_abierta = 1'b1;
            StPaso:     puerta_abierta = 1'b1;
            StFalla:    falla          = 1'b1;
            default:    ;
        endcase
    end

`ifdef CONTADOR_EN
    logic               contar_q, contar_d;
    logic [COUNT_W-1:0] conteo_q, conteo_d;

    always_comb begin
        contar_d = pass_done;
        conteo_d = conteo_q + COUNT_W'(pass_done);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            contar_q <= 1'b0;
            conteo_q <= '0;
        end else begin
            contar_q <= contar_d;
            conteo_q <= conteo_d;
        end
    end

    assign contar = contar_q;
    assign conteo = conteo_q;
`else
    logic unused_pass_done;
    assign unused_pass_done = pass_done;
    assign contar = 1'b0;
    assign conteo = '0;
`endif

endmodule

// File: tb/tb_barrier_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_barrier_gate_ctrl
//
// Self-checking bench for barrier_gate_ctrl with TRAVEL_MAX=8, PASS_MAX=20,
// CLEAR_HOLD=3, COUNT_W=2. Each cycle pushes the expected output vector to a
// scoreboard when inputs are driven and pops/compares it after the edge.
// Counter expectations follow whether CONTADOR_EN is defined for this build.
// ----------------------------------------------------------------------------
module tb_barrier_gate_ctrl;

    localparam int unsigned TRAVEL_MAX = 8;
    localparam int unsigned PASS_MAX   = 20;
    localparam int unsigned CLEAR_HOLD = 3;
    localparam int unsigned COUNT_W    = 2;

`ifdef CONTADOR_EN
    localparam logic CntEn = 1'b1;
`else
    localparam logic CntEn = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               talanquera;
    logic               sensor;
    logic               lim_abierto;
    logic               lim_cerrado;
    logic               motor_abrir;
    logic               motor_cerrar;
    logic               puerta_abierta;
    logic               falla;
    logic               contar;
    logic [COUNT_W-1:0] conteo;

    barrier_gate_ctrl #(
        .TRAVEL_MAX (TRAVEL_MAX),
        .PASS_MAX   (PASS_MAX),
        .CLEAR_HOLD (CLEAR_HOLD),
        .COUNT_W    (COUNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .talanquera     (talanquera),
        .sensor         (sensor),
        .lim_abierto    (lim_abierto),
        .lim_cerrado    (lim_cerrado),
        .motor_abrir    (motor_abrir),
        .motor_cerrar   (motor_cerrar),
        .puerta_abierta (puerta_abierta),
        .falla          (falla),
        .contar         (contar),
        .conteo         (conteo)
    );

    always #5 clk = ~clk;

    // {motor_abrir, motor_cerrar, puerta_abierta, falla, contar, conteo}
    logic [6:0] outs;
    assign outs = {motor_abrir, motor_cerrar, puerta_abierta, falla, contar, conteo};

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] cnt    = 2'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %07b expected %07b", tag, got[6:0], exp[6:0]);
        end
    endtask

    function automatic logic [6:0] ex(input logic ma, input logic mc, input logic pa,
                                      input logic f, input logic c);
        return {ma, mc, pa, f, c & CntEn, cnt};
    endfunction

    task automatic bump();
        if (CntEn) cnt = cnt + 2'd1;
    endtask

    // Drive one cycle of inputs, expect 'e' after the next rising edge.
    task automatic cyc(input string tag, input logic rst, input logic tal, input logic sen,
                       input logic la, input logic lc, input logic [6:0] e);
        exp_t it;
        reset       = rst;
        talanquera  = tal;
        sensor      = sen;
        lim_abierto = la;
        lim_cerrado = lc;
        sb.push_back('{tag, e});
        @(posedge clk);
        #1;
        it = sb.pop_front();
        check_val(it.tag, {25'd0, outs}, {25'd0, it.exp});
        if (motor_abrir && motor_cerrar) check_val("motor_excl", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        cnt = 2'd0;
        cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ex(0, 0, 0, 0, 0));
    endtask

    // Full passage: open in 3 cycles, 5 blocked cycles, 3 clear, close in 4.
    task automatic do_pass(input string tag, input bit extra_req);
        cyc({tag, "/open"}, 1, 1, 1, 0, 1, ex(1, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) cyc({tag, "/abriendo"}, 1, 0, 1, 0, 0, ex(1, 0, 0, 0, 0));
        cyc({tag, "/abierta"}, 1, 0, 1, 1, 0, ex(0, 0, 1, 0, 0));
        if (extra_req) cyc({tag, "/ignore_req"}, 1, 1, 1, 1, 0, ex(0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) cyc({tag, "/paso"}, 1, 0, 0, 1, 0, ex(0, 0, 1, 0, 0));
        for (int i = 0; i < CLEAR_HOLD - 1; i++)
            cyc({tag, "/clear"}, 1, 0, 1, 1, 0, ex(0, 0, 1, 0, 0));
        bump();
        cyc({tag, "/contar"}, 1, 0, 1, 0, 0, ex(0, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++) cyc({tag, "/cerrando"}, 1, 0, 1, 0, 0, ex(0, 1, 0, 0, 0));
        cyc({tag, "/cerrada"}, 1, 0, 1, 0, 1, ex(0, 0, 0, 0, 0));
    endtask

    initial begin
        reset = 1'b0; talanquera = 1'b0; sensor = 1'b1; lim_abierto = 1'b0; lim_cerrado = 1'b1;
        do_reset("reset0");
        do_reset("reset1");
        cyc("idle", 1, 0, 1, 0, 1, ex(0, 0, 0, 0, 0));

        // 1: normal passage
        do_pass("t1", 1'b0);

        // 2: no vehicle, auto-close exactly PASS_MAX cycles after ABIERTA
        cyc("t2/open", 1, 1, 1, 0, 1, ex(1, 0, 0, 0, 0));
        cyc("t2/abierta", 1, 0, 1, 1, 0, ex(0, 0, 1, 0, 0));
        for (int i = 0; i < PASS_MAX - 1; i++)
            cyc("t2/wait", 1, 0, 1, 1, 0, ex(0, 0, 1, 0, 0));
        cyc("t2/auto_close", 1, 0, 1, 1, 0, ex(0, 1, 0, 0, 0));

        // 3: reversal, sensor beats lim_cerrado in the same cycle
        cyc("t3/reversal", 1, 0, 0, 0, 1, ex(1, 0, 0, 0, 0));
        cyc("t3/abierta", 1, 0, 1, 1, 0, ex(0, 0, 1, 0, 0));
        cyc("t3/paso", 1, 0, 0, 1, 0, ex(0, 0, 1, 0, 0));
        for (int i = 0; i < CLEAR_HOLD - 1; i++)
            cyc("t3/clear", 1, 0, 1, 1, 0, ex(0, 0, 1, 0, 0));
        bump();
        cyc("t3/contar", 1, 0, 1, 0, 0, ex(0, 1, 0, 0, 1));
        cyc("t3/cerrada", 1, 0, 1, 0, 1, ex(0, 0, 0, 0, 0));

        // 4: travel timeout while opening
        cyc("t4/open", 1, 1, 1, 0, 1, ex(1, 0, 0, 0, 0));
        for (int i = 0; i < TRAVEL_MAX - 1; i++)
            cyc("t4/abriendo", 1, 0, 1, 0, 0, ex(1, 0, 0, 0, 0));
        cyc("t4/falla", 1, 0, 1, 0, 0, ex(0, 0, 0, 1, 0));
        cyc("t4/req_ign0", 1, 1, 1, 0, 1, ex(0, 0, 0, 1, 0));
        cyc("t4/req_ign1", 1, 0, 1, 0, 1, ex(0, 0, 0, 1, 0));
        cyc("t4/req_ign2", 1, 1, 1, 0, 1, ex(0, 0, 0, 1, 0));
        do_reset("t4/reset");

        // 5: counter wrap, ignored request while open, both limits high
        do_pass("t5a", 1'b1);
        do_pass("t5b", 1'b0);
        do_pass("t5c", 1'b0);
        do_pass("t5d", 1'b0);
        do_pass("t5e", 1'b0);
        cyc("t5/both_lim", 1, 0, 1, 1, 1, ex(0, 0, 0, 1, 0));
        cyc("t5/stuck", 1, 0, 1, 0, 1, ex(0, 0, 0, 1, 0));
        do_reset("t5/reset");

        // 6: reset while opening, then a clean pass
        cyc("t6/open", 1, 1, 1, 0, 1, ex(1, 0, 0, 0, 0));
        cyc("t6/abriendo", 1, 0, 1, 0, 0, ex(1, 0, 0, 0, 0));
        cyc("t6/reset", 0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0));
        cyc("t6/idle", 1, 0, 1, 0, 1, ex(0, 0, 0, 0, 0));
        do_pass("t6", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
